pm_thread_scheduler: RTL and testbench
======================================

# pm_thread_scheduler

Multi-thread request scheduler for the near-PM processing path. Accepts persistent-memory commands (logging, checkpoint, copy) from `NUM_THREADS` host-thread request ports and dispatches them to `NUM_UNITS` identical processing units. Arbitration is round-robin, with at most one outstanding command per thread to preserve per-thread persist ordering. Sits between the host request interface and the processing-unit array in the top-level block design, and is started by the global `start` pulse.

## Interface
- `NUM_THREADS`, 4: requester count, ≥2, power of two not required
- `NUM_UNITS`, 2: processing units, ≥1
- `CMD_W`, 64: command word width
- `TID_W`, $clog2(NUM_THREADS): thread-ID width
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-low; low clears all state
- `start` in 1: pulse; IDLE→RUN
- `stop` in 1: pulse; RUN→DRAIN
- `req_valid` in NUM_THREADS: per-thread command valid
- `req_cmd` in NUM_THREADS*CMD_W: per-thread command, thread i at [i*CMD_W +: CMD_W]
- `req_ready` out NUM_THREADS: accept grant; handshake = valid & ready
- `unit_start` out NUM_UNITS: one-cycle launch pulse per unit
- `unit_cmd` out NUM_UNITS*CMD_W: registered command per unit
- `unit_tid` out NUM_UNITS*TID_W: owning thread per unit
- `unit_done` in NUM_UNITS: one-cycle completion pulse per unit
- `comp_valid` out NUM_UNITS: completion report pulse
- `comp_tid` out NUM_UNITS*TID_W: thread of completed command
- `busy` out 1: high in RUN or DRAIN
- `idle` out 1: high in IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN. IDLE→RUN when `start`=1. RUN→DRAIN when `stop`=1. DRAIN→IDLE when no unit busy. `start` outside IDLE is ignored; `stop` outside RUN is ignored.
- Per-unit `unit_busy` flag; per-thread `outstanding` flag.
- A thread is eligible when: `req_valid[i]` is high, `outstanding[i]`=0, state=RUN, and at least one unit is free.
- Grant: one dispatch per cycle at most. Round-robin search starts at `rr_ptr` and wraps. After a grant to thread i, `rr_ptr`←(i+1) mod NUM_THREADS. `rr_ptr` is unchanged when there is no grant.
- Target unit: the lowest-index free unit.
- `req_ready` is one-hot or zero.
- Dispatch sets `unit_busy[u]` and `outstanding[i]`, latches `unit_cmd[u]`←cmd and `unit_tid[u]`←i.
- `unit_done[u]` is honoured only while `unit_busy[u]`; spurious pulses are ignored. On completion: clear `unit_busy[u]`, clear `outstanding[unit_tid[u]]`, pulse `comp_valid[u]`, drive `comp_tid[u]`.
- Simultaneous completions on several units are all reported in the same cycle.
- Reset (async, any state): state=IDLE, rr_ptr=0, all flags 0.
- Reset values of outputs: `req_ready`=0, `unit_start`=0, `unit_cmd`=0, `unit_tid`=0, `comp_valid`=0, `comp_tid`=0, `busy`=0, `idle`=1. In-flight commands are discarded.

## Timing
- `start` high at edge T → RUN from T. The first grant is possible in the cycle following T.
- `req_ready` is combinational from registered state plus `req_valid`.
- Handshake in cycle T → `unit_start[u]`=1 in cycle T+1 only. `unit_cmd[u]`/`unit_tid[u]` are valid from T+1 and held until the next dispatch to u.
- `unit_done[u]` in cycle T → `comp_valid[u]` in T+1. In T+1, unit u is free and thread `unit_tid[u]` is eligible again (re-dispatch possible in T+1).
- Minimum per-unit turnaround: done in T, new `unit_start` in T+2.
- `stop` in the same cycle as an eligible request: the grant still occurs in that cycle, then DRAIN.
- DRAIN→IDLE at the edge after the last busy flag clears; `idle`=1 in that next cycle.

## Structure
- Package `pm_sched_pkg`: state enum `sched_state_t` {IDLE, RUN, DRAIN}, default `CMD_W`, and helper function `first_free(mask)` returning the lowest set index.
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs: `req[N]`, `ptr`
  - outputs: one-hot `gnt[N]`, `gnt_idx`
  - purely combinational
  - `rr_ptr` register stays in the parent.

## Test plan
- Reset/idle: hold `reset`=0 for 2 cycles, release → `idle`=1, all outputs 0. `req_valid`=4'b1111 without `start` → no `req_ready`.
- Round-robin fairness: `start`, `req_valid`=4'b1111, units complete 3 cycles after start → grant order 0,1,2,3,0,…; no thread starved.
- Per-thread ordering: thread 2 is the only requester, 2 units, cmd 0xA then 0xB → second grant only after `comp_valid` with `comp_tid`=2.
- Unit saturation: 4 threads valid, both units busy → `req_ready`=0. `unit_done`=2'b11 in cycle T → `comp_valid`=2'b11 in T+1 and one new dispatch in T+1.
- Drain: `stop` while unit 1 busy → no new grants. `idle`=1 one cycle after unit 1 completion is reported. A spurious `unit_done[0]` causes no `comp_valid[0]`.
- Reset mid-op: assert `reset` with both units busy → outputs return to reset values immediately. After release and `start`, the grant begins at thread 0.

Source files
------------

// File: rtl/pm_sched_pkg.sv
// Shared types and helpers for the near-PM thread scheduler.
// The state enum, the default command width, and the lowest-free-unit picker.
package pm_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   localparam int DEFAULT_CMD_W = 64;

   // Returns the lowest set index of mask, or 0 when mask is empty.
   function automatic int first_free(input logic [31:0] mask);
      int idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (mask[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping around; the pointer register itself lives in the parent.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic w_found;
   int   w_idx;

   // NOTE: every output and temporary gets a default first so no latch is inferred.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = (int'(ptr) + k) % N;
         if (!w_found && req[w_idx]) begin
            w_found      = 1'b1;
            gnt[w_idx]   = 1'b1;
            gnt_idx      = IDX_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/pm_thread_scheduler.sv
// Dispatches per-thread persistent-memory commands to a pool of processing units,
// round-robin across threads with at most one command in flight per thread.
module pm_thread_scheduler
   import pm_sched_pkg::*;
#(
   parameter int NUM_THREADS = 4,
   parameter int NUM_UNITS   = 2,
   parameter int CMD_W       = DEFAULT_CMD_W,
   parameter int TID_W       = $clog2(NUM_THREADS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          stop,
   input  logic [NUM_THREADS-1:0]        req_valid,
   input  logic [NUM_THREADS*CMD_W-1:0]  req_cmd,
   output logic [NUM_THREADS-1:0]        req_ready,
   output logic [NUM_UNITS-1:0]          unit_start,
   output logic [NUM_UNITS*CMD_W-1:0]    unit_cmd,
   output logic [NUM_UNITS*TID_W-1:0]    unit_tid,
   input  logic [NUM_UNITS-1:0]          unit_done,
   output logic [NUM_UNITS-1:0]          comp_valid,
   output logic [NUM_UNITS*TID_W-1:0]    comp_tid,
   output logic                          busy,
   output logic                          idle
);

   sched_state_t             r_state;
   sched_state_t             w_next_state;
   logic [TID_W-1:0]         r_rr_ptr;
   logic [NUM_THREADS-1:0]   r_outstanding;
   logic [NUM_UNITS-1:0]     r_unit_busy;
   logic [NUM_UNITS-1:0]     r_unit_start;
   logic [NUM_UNITS-1:0]     r_comp_valid;
   logic [CMD_W-1:0]         r_unit_cmd [NUM_UNITS];
   logic [TID_W-1:0]         r_unit_tid [NUM_UNITS];
   logic [TID_W-1:0]         r_comp_tid [NUM_UNITS];

   logic [NUM_UNITS-1:0]     w_free;
   logic [NUM_UNITS-1:0]     w_done;
   logic                     w_can_grant;
   logic [NUM_THREADS-1:0]   w_elig;
   logic [NUM_THREADS-1:0]   w_gnt;
   logic [TID_W-1:0]         w_gnt_idx;
   logic                     w_dispatch;
   logic [CMD_W-1:0]         w_gnt_cmd;
   logic [NUM_THREADS-1:0]   w_out_clr;
   int                       w_tgt;

   assign w_free      = ~r_unit_busy;
   // Done pulses from idle units are spurious and dropped here.
   assign w_done      = unit_done & r_unit_busy;
   assign w_can_grant = (r_state == RUN) && (|w_free);
   assign w_elig      = req_valid & ~r_outstanding & {NUM_THREADS{w_can_grant}};
   assign w_dispatch  = |w_gnt;
   assign w_tgt       = first_free(32'(w_free));
   assign req_ready   = w_gnt;

   rr_arbiter #(
      .N     (NUM_THREADS),
      .IDX_W (TID_W)
   ) u_rr_arbiter (
      .req     (w_elig),
      .ptr     (r_rr_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   always_comb begin
      w_gnt_cmd = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (w_gnt[i]) w_gnt_cmd = req_cmd[i*CMD_W +: CMD_W];
      end
   end

   always_comb begin
      w_out_clr = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (w_done[u]) w_out_clr[r_unit_tid[u]] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start)        w_next_state = RUN;
         RUN:     if (stop)         w_next_state = DRAIN;
         DRAIN:   if (~|r_unit_busy) w_next_state = IDLE;
         default:                   w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == RUN) || (r_state == DRAIN);
      idle = (r_state == IDLE);
   end

   // NOTE: the per-unit command/tid arrays are visible outputs with defined reset values, so they are reset too.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rr_ptr      <= '0;
         r_outstanding <= '0;
         r_unit_busy   <= '0;
         r_unit_start  <= '0;
         r_comp_valid  <= '0;
         for (int u = 0; u < NUM_UNITS; u++) begin
            r_unit_cmd[u] <= '0;
            r_unit_tid[u] <= '0;
            r_comp_tid[u] <= '0;
         end
      end else begin
         r_unit_start  <= '0;
         r_comp_valid  <= w_done;
         r_outstanding <= (r_outstanding & ~w_out_clr) | w_gnt;
         if (w_dispatch) begin
            if (int'(w_gnt_idx) == NUM_THREADS - 1) r_rr_ptr <= '0;
            else                                    r_rr_ptr <= w_gnt_idx + 1'b1;
         end
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_done[u]) begin
               r_unit_busy[u] <= 1'b0;
               r_comp_tid[u]  <= r_unit_tid[u];
            end
            // A dispatch only ever targets a free unit, so it never collides with a completion.
            if (w_dispatch && (u == w_tgt)) begin
               r_unit_busy[u]  <= 1'b1;
               r_unit_start[u] <= 1'b1;
               r_unit_cmd[u]   <= w_gnt_cmd;
               r_unit_tid[u]   <= w_gnt_idx;
            end
         end
      end
   end

   assign unit_start = r_unit_start;
   assign comp_valid = r_comp_valid;

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit_out
      assign unit_cmd[u*CMD_W +: CMD_W] = r_unit_cmd[u];
      assign unit_tid[u*TID_W +: TID_W] = r_unit_tid[u];
      assign comp_tid[u*TID_W +: TID_W] = r_comp_tid[u];
   end

endmodule

// File: tb/tb_pm_thread_scheduler.sv
// Self-checking bench for pm_thread_scheduler: a hand-derived vector table, directed
// ordering/reset sequences, and random traffic against a behavioural model.
module tb_pm_thread_scheduler;

   localparam int NT = 4;
   localparam int NU = 2;
   localparam int CW = 64;
   localparam int TW = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             stop;
   logic [NT-1:0]    req_valid;
   logic [NT*CW-1:0] req_cmd;
   logic [NT-1:0]    req_ready;
   logic [NU-1:0]    unit_start;
   logic [NU*CW-1:0] unit_cmd;
   logic [NU*TW-1:0] unit_tid;
   logic [NU-1:0]    unit_done;
   logic [NU-1:0]    comp_valid;
   logic [NU*TW-1:0] comp_tid;
   logic             busy;
   logic             idle;

   pm_thread_scheduler #(
      .NUM_THREADS (NT),
      .NUM_UNITS   (NU),
      .CMD_W       (CW),
      .TID_W       (TW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .req_valid  (req_valid),
      .req_cmd    (req_cmd),
      .req_ready  (req_ready),
      .unit_start (unit_start),
      .unit_cmd   (unit_cmd),
      .unit_tid   (unit_tid),
      .unit_done  (unit_done),
      .comp_valid (comp_valid),
      .comp_tid   (comp_tid),
      .busy       (busy),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
      end
   endtask

   // Behavioural model: 0=idle, 1=run, 2=drain.
   int          m_state;
   int          m_ptr;
   bit          m_out    [NT];
   bit          m_ubusy  [NU];
   int          m_utid   [NU];
   logic [CW-1:0] m_ucmd [NU];
   bit          m_ustart [NU];
   bit          m_comp   [NU];
   int          m_ctid   [NU];

   task automatic m_reset();
      m_state = 0;
      m_ptr   = 0;
      for (int t = 0; t < NT; t++) m_out[t] = 1'b0;
      for (int u = 0; u < NU; u++) begin
         m_ubusy[u] = 1'b0; m_utid[u] = 0; m_ucmd[u] = '0;
         m_ustart[u] = 1'b0; m_comp[u] = 1'b0; m_ctid[u] = 0;
      end
   endtask

   function automatic int m_free_unit();
      for (int u = 0; u < NU; u++) if (!m_ubusy[u]) return u;
      return -1;
   endfunction

   function automatic int m_grant();
      if (m_state != 1 || m_free_unit() < 0) return -1;
      for (int k = 0; k < NT; k++) begin
         int t;
         t = (m_ptr + k) % NT;
         if (req_valid[t] && !m_out[t]) return t;
      end
      return -1;
   endfunction

   task automatic m_check();
      logic [NT-1:0]    e_rdy;
      logic [NU-1:0]    e_us, e_comp;
      logic [NU*CW-1:0] e_cmd;
      logic [NU*TW-1:0] e_tid, e_ctid;
      int g;
      e_rdy = '0; e_us = '0; e_comp = '0; e_cmd = '0; e_tid = '0; e_ctid = '0;
      g = m_grant();
      if (g >= 0) e_rdy[g] = 1'b1;
      for (int u = 0; u < NU; u++) begin
         e_us[u]            = m_ustart[u];
         e_comp[u]          = m_comp[u];
         e_cmd[u*CW +: CW]  = m_ucmd[u];
         e_tid[u*TW +: TW]  = TW'(m_utid[u]);
         e_ctid[u*TW +: TW] = TW'(m_ctid[u]);
      end
      check("m_req_ready",  128'(req_ready),  128'(e_rdy));
      check("m_unit_start", 128'(unit_start), 128'(e_us));
      check("m_unit_cmd",   128'(unit_cmd),   128'(e_cmd));
      check("m_unit_tid",   128'(unit_tid),   128'(e_tid));
      check("m_comp_valid", 128'(comp_valid), 128'(e_comp));
      check("m_comp_tid",   128'(comp_tid),   128'(e_ctid));
      check("m_busy",       128'(busy),       128'(m_state != 0));
      check("m_idle",       128'(idle),       128'(m_state == 0));
   endtask

   task automatic m_step();
      int  g, fu;
      bit  any_busy;
      bit  hd [NU];
      g  = m_grant();
      fu = m_free_unit();
      any_busy = 1'b0;
      for (int u = 0; u < NU; u++) begin
         hd[u] = unit_done[u] && m_ubusy[u];
         if (m_ubusy[u]) any_busy = 1'b1;
      end
      case (m_state)
         0: if (start)     m_state = 1;
         1: if (stop)      m_state = 2;
         2: if (!any_busy) m_state = 0;
         default: m_state = 0;
      endcase
      for (int u = 0; u < NU; u++) begin
         m_ustart[u] = 1'b0;
         m_comp[u]   = hd[u];
         if (hd[u]) begin
            m_ctid[u]         = m_utid[u];
            m_ubusy[u]        = 1'b0;
            m_out[m_utid[u]]  = 1'b0;
         end
      end
      if (g >= 0) begin
         m_ubusy[fu]  = 1'b1;
         m_utid[fu]   = g;
         m_ucmd[fu]   = req_cmd[g*CW +: CW];
         m_ustart[fu] = 1'b1;
         m_out[g]     = 1'b1;
         m_ptr        = (g + 1) % NT;
      end
   endtask

   // Called one time unit after a rising edge: drive, settle, compare against the model.
   task automatic drive(input logic st, input logic sp, input logic [NT-1:0] v, input logic [NU-1:0] d);
      start = st; stop = sp; req_valid = v; unit_done = d;
      #1;
      m_check();
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
      cyc_n++;
   endtask

   typedef struct {
      logic          st;
      logic          sp;
      logic [NT-1:0] v;
      logic [NU-1:0] d;
      logic [NT-1:0] e_rdy;
      logic [NU-1:0] e_us;
      logic [NU-1:0] e_comp;
      logic          e_idle;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic st, input logic sp, input logic [NT-1:0] v, input logic [NU-1:0] d,
                      input logic [NT-1:0] e_rdy, input logic [NU-1:0] e_us,
                      input logic [NU-1:0] e_comp, input logic e_idle);
      vec_t r;
      r.st = st; r.sp = sp; r.v = v; r.d = d;
      r.e_rdy = e_rdy; r.e_us = e_us; r.e_comp = e_comp; r.e_idle = e_idle;
      tbl.push_back(r);
   endtask

   initial begin
      // Fairness, saturation, stop-with-grant, drain and spurious-done vectors.
      add(1'b0, 1'b1, 4'hF, 2'b00, 4'h0, 2'b00, 2'b00, 1'b1);
      add(1'b1, 1'b0, 4'hF, 2'b00, 4'h0, 2'b00, 2'b00, 1'b1);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h1, 2'b00, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h2, 2'b01, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h0, 2'b10, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b01, 4'h0, 2'b00, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h4, 2'b00, 2'b01, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b10, 4'h0, 2'b01, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h8, 2'b00, 2'b10, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b11, 4'h0, 2'b10, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h1, 2'b00, 2'b11, 1'b0);
      add(1'b0, 1'b1, 4'hF, 2'b00, 4'h2, 2'b01, 2'b00, 1'b0);
      add(1'b1, 1'b0, 4'hF, 2'b00, 4'h0, 2'b10, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b01, 4'h0, 2'b00, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b01, 4'h0, 2'b00, 2'b01, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h0, 2'b00, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b10, 4'h0, 2'b00, 2'b00, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h0, 2'b00, 2'b10, 1'b0);
      add(1'b0, 1'b0, 4'hF, 2'b00, 4'h0, 2'b00, 2'b00, 1'b1);

      reset = 1'b0; start = 1'b0; stop = 1'b0; req_valid = '0; unit_done = '0;
      for (int i = 0; i < NT; i++) req_cmd[i*CW +: CW] = 64'h1000 + 64'(i);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 4'hF, 2'b00);
      check("rst_idle", 128'(idle), 128'(1));
      check("rst_ready", 128'(req_ready), 128'(0));
      reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sp, tbl[i].v, tbl[i].d);
         check($sformatf("tbl%0d_ready", i), 128'(req_ready),  128'(tbl[i].e_rdy));
         check($sformatf("tbl%0d_ustart", i), 128'(unit_start), 128'(tbl[i].e_us));
         check($sformatf("tbl%0d_comp", i), 128'(comp_valid), 128'(tbl[i].e_comp));
         check($sformatf("tbl%0d_idle", i), 128'(idle), 128'(tbl[i].e_idle));
         check($sformatf("tbl%0d_busy", i), 128'(busy), 128'(!tbl[i].e_idle));
         tick();
      end

      // Per-thread ordering: thread 2 alone, second command waits for its completion.
      req_cmd[2*CW +: CW] = 64'hA;
      drive(1'b1, 1'b0, 4'b0100, 2'b00);
      check("ord_idle_ready", 128'(req_ready), 128'(0));
      tick();
      drive(1'b0, 1'b0, 4'b0100, 2'b00);
      check("ord_grant1", 128'(req_ready), 128'(4'b0100));
      tick();
      req_cmd[2*CW +: CW] = 64'hB;
      drive(1'b0, 1'b0, 4'b0100, 2'b00);
      check("ord_blocked", 128'(req_ready), 128'(0));
      check("ord_ustart", 128'(unit_start), 128'(2'b01));
      check("ord_cmd_a", 128'(unit_cmd[CW-1:0]), 128'(64'hA));
      check("ord_tid", 128'(unit_tid[TW-1:0]), 128'(2));
      tick();
      drive(1'b0, 1'b0, 4'b0100, 2'b01);
      check("ord_blocked2", 128'(req_ready), 128'(0));
      tick();
      drive(1'b0, 1'b0, 4'b0100, 2'b00);
      check("ord_comp", 128'(comp_valid), 128'(2'b01));
      check("ord_comp_tid", 128'(comp_tid[TW-1:0]), 128'(2));
      check("ord_grant2", 128'(req_ready), 128'(4'b0100));
      tick();
      drive(1'b0, 1'b0, 4'b0000, 2'b00);
      check("ord_cmd_b", 128'(unit_cmd[CW-1:0]), 128'(64'hB));
      tick();

      // Reset mid-operation with both units busy.
      drive(1'b0, 1'b0, 4'b0001, 2'b00);
      check("mid_grant_t0", 128'(req_ready), 128'(4'b0001));
      tick();
      drive(1'b0, 1'b0, 4'hF, 2'b00);
      check("mid_saturated", 128'(req_ready), 128'(0));
      reset = 1'b0;
      #1;
      check("mid_rst_ready",  128'(req_ready),  128'(0));
      check("mid_rst_ustart", 128'(unit_start), 128'(0));
      check("mid_rst_cmd",    128'(unit_cmd),   128'(0));
      check("mid_rst_tid",    128'(unit_tid),   128'(0));
      check("mid_rst_comp",   128'(comp_valid), 128'(0));
      check("mid_rst_ctid",   128'(comp_tid),   128'(0));
      check("mid_rst_busy",   128'(busy),       128'(0));
      check("mid_rst_idle",   128'(idle),       128'(1));
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b1, 1'b0, 4'hF, 2'b00);
      tick();
      drive(1'b0, 1'b0, 4'hF, 2'b00);
      check("post_rst_first_grant", 128'(req_ready), 128'(4'b0001));
      tick();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic [NU-1:0] d;
         for (int i = 0; i < NT; i++) req_cmd[i*CW +: CW] = {$urandom, $urandom};
         for (int u = 0; u < NU; u++)
            d[u] = m_ubusy[u] ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
         drive(($urandom % 16) == 0, ($urandom % 40) == 0, NT'($urandom), d);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
